// File: rtl/dbg_abs_cmd.sv
// Abstract command engine for a debug module: decodes and validates a DMI command,
// runs one register access on the responder bus and keeps data0 and the sticky cmderr.
module dbg_abs_cmd (
  input  logic        cpu_clk,
  input  logic        cpu_rstn,
  input  logic        dmi_cmd_wr,
  input  logic        dmi_data0_wr,
  input  logic        dmi_acs_wr,
  input  logic [31:0] dmi_wdata,
  output logic [31:0] data0,
  output logic        busy,
  output logic [2:0]  cmderr,
  input  logic        dbg_mode,
  output logic        dbg_reg_access,
  output logic        dbg_wr1_rd0,
  output logic [15:0] dbg_regno,
  output logic [31:0] dbg_write_data,
  input  logic [31:0] dbg_read_data,
  input  logic        dbg_read_data_valid,
  output logic [2:0]  fsm_state,
  output logic [31:0] command
);

  // Responder handshake: dbg_reg_access is a one-cycle request (EXEC); the read reply
  // is accepted on any cycle where dbg_read_data_valid is high in EXEC or WAIT.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_EXEC  = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  wait_cnt;
  logic [31:0] cmd_q;
  logic        cmd_fail;
  logic [2:0]  cmderr_nxt;
  logic        fsm_err_set;
  logic [2:0]  fsm_err_val;
  logic        busy_err;
  logic        rd_load;
  logic        cmd_accept;

  logic [7:0]  cmdtype;
  logic [2:0]  aarsize;
  logic        postinc;
  logic        postexec;
  logic        transfer;
  logic        write;
  logic        bad_cmd;

  assign cmdtype  = cmd_q[31:24];
  assign aarsize  = cmd_q[22:20];
  assign postinc  = cmd_q[19];
  assign postexec = cmd_q[18];
  assign transfer = cmd_q[17];
  assign write    = cmd_q[16];
  assign bad_cmd  = (cmdtype != 8'd0) || postexec || (transfer && (aarsize != 3'd2));

  assign cmd_accept = (state == S_IDLE) && dmi_cmd_wr && (cmderr == 3'd0);
  assign command    = cmd_q;

  // State register
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) state <= S_IDLE;
    else           state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (cmd_accept) state_nxt = S_CHECK;
      S_CHECK: begin
        if (bad_cmd || !dbg_mode || !transfer) state_nxt = S_DONE;
        else                                   state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (write || dbg_read_data_valid) state_nxt = S_DONE;
        else                              state_nxt = S_WAIT;
      end
      S_WAIT:  if (dbg_read_data_valid || (wait_cnt == 2'd2)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy           = (state != S_IDLE);
    dbg_reg_access = 1'b0;
    dbg_wr1_rd0    = 1'b0;
    dbg_regno      = 16'd0;
    dbg_write_data = 32'd0;
    fsm_state      = state;
    if (state == S_EXEC) begin
      dbg_reg_access = 1'b1;
      dbg_wr1_rd0    = write;
      dbg_regno      = cmd_q[15:0];
      dbg_write_data = data0;
    end
  end

  // Error sources; a command's own error outranks the busy error and both outrank W1C.
  always_comb begin
    fsm_err_set = 1'b0;
    fsm_err_val = 3'd0;
    if (state == S_CHECK) begin
      if (bad_cmd) begin
        fsm_err_set = 1'b1;
        fsm_err_val = 3'd2;
      end else if (!dbg_mode) begin
        fsm_err_set = 1'b1;
        fsm_err_val = 3'd4;
      end
    end else if ((state == S_WAIT) && !dbg_read_data_valid && (wait_cnt == 2'd2)) begin
      fsm_err_set = 1'b1;
      fsm_err_val = 3'd3;
    end
  end

  assign busy_err = busy && (dmi_cmd_wr || dmi_data0_wr) && (cmderr == 3'd0);
  assign rd_load  = dbg_read_data_valid &&
                    (((state == S_EXEC) && !write) || (state == S_WAIT));

  always_comb begin
    cmderr_nxt = cmderr;
    if (dmi_acs_wr)  cmderr_nxt = cmderr & ~dmi_wdata[10:8];
    if (busy_err)    cmderr_nxt = 3'd1;
    if (fsm_err_set) cmderr_nxt = fsm_err_val;
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      cmd_q    <= 32'd0;
      cmd_fail <= 1'b0;
      wait_cnt <= 2'd0;
      data0    <= 32'd0;
      cmderr   <= 3'd0;
    end else begin
      cmderr <= cmderr_nxt;
      if (cmd_accept) begin
        cmd_q    <= dmi_wdata;
        cmd_fail <= 1'b0;
      end else begin
        if (fsm_err_set) cmd_fail <= 1'b1;
        if ((state == S_DONE) && transfer && postinc && !cmd_fail)
          cmd_q[15:0] <= cmd_q[15:0] + 16'd1;
      end
      // Counter is held at zero outside WAIT, so every entry starts from zero.
      if (state == S_WAIT) wait_cnt <= wait_cnt + 2'd1;
      else                 wait_cnt <= 2'd0;
      if (rd_load)                                  data0 <= dbg_read_data;
      else if ((state == S_IDLE) && dmi_data0_wr)   data0 <= dmi_wdata;
    end
  end

endmodule

// File: tb/tb_dbg_abs_cmd.sv
// Randomized bench for dbg_abs_cmd: a per-command outcome model predicts busy length,
// responder accesses, cmderr, data0 and regno, and a monitor scores every access.
module tb_dbg_abs_cmd;

  logic        cpu_clk = 1'b0;
  logic        cpu_rstn = 1'b1;
  logic        dmi_cmd_wr = 1'b0;
  logic        dmi_data0_wr = 1'b0;
  logic        dmi_acs_wr = 1'b0;
  logic [31:0] dmi_wdata = 32'd0;
  logic [31:0] data0;
  logic        busy;
  logic [2:0]  cmderr;
  logic        dbg_mode = 1'b1;
  logic        dbg_reg_access;
  logic        dbg_wr1_rd0;
  logic [15:0] dbg_regno;
  logic [31:0] dbg_write_data;
  logic [31:0] dbg_read_data = 32'd0;
  logic        dbg_read_data_valid = 1'b0;
  logic [2:0]  fsm_state;
  logic [31:0] command;

  dbg_abs_cmd dut (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn),
    .dmi_cmd_wr(dmi_cmd_wr), .dmi_data0_wr(dmi_data0_wr), .dmi_acs_wr(dmi_acs_wr),
    .dmi_wdata(dmi_wdata), .data0(data0), .busy(busy), .cmderr(cmderr),
    .dbg_mode(dbg_mode), .dbg_reg_access(dbg_reg_access), .dbg_wr1_rd0(dbg_wr1_rd0),
    .dbg_regno(dbg_regno), .dbg_write_data(dbg_write_data),
    .dbg_read_data(dbg_read_data), .dbg_read_data_valid(dbg_read_data_valid),
    .fsm_state(fsm_state), .command(command)
  );

  always #5 cpu_clk = ~cpu_clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [48:0] exp_q[$];
  logic [2:0]  m_err = 3'd0;
  logic [31:0] m_data0 = 32'd0;
  logic [31:0] m_cmd = 32'd0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every observed access must match the next predicted one.
  always @(negedge cpu_clk) begin
    if (dbg_reg_access === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_access", 64'd1, 64'd0);
      else check("access", {dbg_wr1_rd0, dbg_regno, dbg_write_data}, exp_q.pop_front());
    end
  end

  task automatic idle_inputs();
    dmi_cmd_wr = 1'b0; dmi_data0_wr = 1'b0; dmi_acs_wr = 1'b0;
    dbg_read_data_valid = 1'b0;
  endtask

  task automatic write_data0(input logic [31:0] v);
    @(negedge cpu_clk);
    dmi_data0_wr = 1'b1; dmi_wdata = v;
    @(negedge cpu_clk);
    dmi_data0_wr = 1'b0;
    m_data0 = v;
    check("data0_idle_wr", data0, m_data0);
  endtask

  task automatic acs_clear(input logic [2:0] mask);
    @(negedge cpu_clk);
    dmi_acs_wr = 1'b1; dmi_wdata = {21'd0, mask, 8'd0};
    @(negedge cpu_clk);
    dmi_acs_wr = 1'b0;
    m_err = m_err & ~mask;
    check("acs_clear", cmderr, m_err);
  endtask

  task automatic ign_cmd(input logic [31:0] cmd);
    int was_busy;
    was_busy = 0;
    @(negedge cpu_clk);
    dmi_cmd_wr = 1'b1; dmi_wdata = cmd;
    for (int i = 1; i <= 4; i++) begin
      @(negedge cpu_clk);
      dmi_cmd_wr = 1'b0;
      if (busy !== 1'b0) was_busy = 1;
    end
    check("ignored_busy", was_busy, 0);
    check("ignored_cmd", command, m_cmd);
    check("ignored_err", cmderr, m_err);
  endtask

  // One accepted command. d = responder delay after the access (4 = never replies).
  // Cycle i counts from the strobe cycle (i = 0).
  task automatic do_cmd(input logic [31:0] cmd, input logic mode, input logic mode_late,
                        input int d, input logic [31:0] rdata, input logic scmd,
                        input logic sd0, input int acs_at, input logic [2:0] acs_mask);
    logic       bad, acc, is_rd;
    logic [2:0] ferr, e, nx;
    int         ferr_at, blen, first_idle;
    logic [31:0] d0_exp;
    logic [15:0] rn_exp;
    bad = (cmd[31:24] != 8'd0) || cmd[18] || (cmd[17] && (cmd[22:20] != 3'd2));
    acc = 1'b0; ferr = 3'd0; ferr_at = 0; blen = 2;
    if (bad) begin ferr = 3'd2; ferr_at = 1; end
    else if (!mode) begin ferr = 3'd4; ferr_at = 1; end
    else if (cmd[17]) begin
      acc = 1'b1;
      if (cmd[16]) blen = 3;
      else if (d <= 3) blen = 3 + d;
      else begin blen = 6; ferr = 3'd3; ferr_at = 5; end
    end
    is_rd  = acc && !cmd[16];
    d0_exp = (is_rd && d <= 3) ? rdata : m_data0;
    rn_exp = (cmd[17] && cmd[19] && ferr_at == 0) ? cmd[15:0] + 16'd1 : cmd[15:0];
    e = m_err;
    for (int i = 1; i <= 8; i++) begin
      nx = (acs_at == i) ? (e & ~acs_mask) : e;
      if (i == 2 && (scmd || sd0) && e == 3'd0) nx = 3'd1;
      if (ferr_at == i) nx = ferr;
      e = nx;
    end
    if (acc) exp_q.push_back({cmd[16], cmd[15:0], m_data0});

    @(negedge cpu_clk);
    dmi_cmd_wr = 1'b1; dmi_wdata = cmd; dbg_mode = mode;
    first_idle = 0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge cpu_clk);
      if (busy === 1'b0 && first_idle == 0) first_idle = i;
      if (i == 2) check("access_cycle", dbg_reg_access, acc);
      if (i == blen) check("done_outputs_zero",
                           {dbg_reg_access, dbg_wr1_rd0, dbg_regno, dbg_write_data}, 64'd0);
      dmi_cmd_wr   = (i == 2) && scmd;
      dmi_data0_wr = (i == 2) && sd0;
      dmi_wdata    = $urandom;
      dmi_acs_wr   = (i == acs_at);
      if (i == acs_at) dmi_wdata = {21'd0, acs_mask, 8'd0};
      dbg_read_data_valid = is_rd && (d <= 3) && (i == 2 + d);
      dbg_read_data = dbg_read_data_valid ? rdata : $urandom;
      dbg_mode = (i >= 2) ? mode_late : mode;
    end
    idle_inputs();
    check("busy_len", first_idle, blen + 1);
    m_err = e; m_data0 = d0_exp; m_cmd = {cmd[31:16], rn_exp};
    check("cmderr", cmderr, m_err);
    check("data0", data0, m_data0);
    check("command", command, m_cmd);
  endtask

  task automatic reset_in_wait();
    @(negedge cpu_clk);
    dmi_cmd_wr = 1'b1; dmi_wdata = 32'h0022_1000; dbg_mode = 1'b1;
    exp_q.push_back({1'b0, 16'h1000, m_data0});
    for (int i = 1; i <= 4; i++) begin
      @(negedge cpu_clk);
      dmi_cmd_wr = 1'b0; dbg_read_data_valid = 1'b0;
    end
    check("wait_before_reset", fsm_state, 3'd3);
    #2 cpu_rstn = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_cmderr", cmderr, 0);
    check("rst_data0", data0, 0);
    check("rst_dbg", {dbg_reg_access, dbg_wr1_rd0, dbg_regno, dbg_write_data}, 64'd0);
    check("rst_cmd", command, 0);
    @(negedge cpu_clk);
    cpu_rstn = 1'b1;
    m_err = 3'd0; m_data0 = 32'd0; m_cmd = 32'd0;
    repeat (8) @(negedge cpu_clk);
    check("post_rst_idle", {busy, fsm_state}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] c, r;
    #1 cpu_rstn = 1'b0;
    #2;
    check("reset_busy", busy, 0);
    check("reset_cmderr", cmderr, 0);
    check("reset_data0", data0, 0);
    check("reset_dbg", {dbg_reg_access, dbg_wr1_rd0, dbg_regno, dbg_write_data}, 64'd0);
    check("reset_state", fsm_state, 0);
    @(negedge cpu_clk);
    cpu_rstn = 1'b1;
    @(negedge cpu_clk);

    write_data0(32'h1234_5678);
    do_cmd(32'h0023_07B0, 1, 1, 0, 32'd0, 0, 0, 0, 3'd0);
    do_cmd(32'h0022_07A1, 1, 1, 0, 32'hDEAD_BEEF, 0, 0, 0, 3'd0);
    do_cmd(32'h0022_1234, 1, 1, 4, 32'd0, 0, 0, 0, 3'd0);
    acs_clear(3'b111);
    do_cmd(32'h0022_1000, 0, 0, 0, 32'd0, 0, 0, 0, 3'd0);
    ign_cmd(32'h0023_07B0);
    acs_clear(3'b111);
    do_cmd(32'h002A_FFFF, 1, 1, 1, 32'hCAFE_0001, 0, 0, 0, 3'd0);
    do_cmd(32'h0033_1000, 1, 1, 0, 32'd0, 0, 0, 0, 3'd0);
    acs_clear(3'b111);
    do_cmd(32'h0023_07B0, 1, 1, 0, 32'd0, 1, 1, 0, 3'd0);
    acs_clear(3'b111);
    do_cmd(32'h0022_0042, 1, 1, 2, 32'h0BAD_F00D, 1, 1, 0, 3'd0);
    acs_clear(3'b111);
    do_cmd(32'h0022_0043, 1, 1, 4, 32'd0, 1, 0, 5, 3'b111);
    acs_clear(3'b111);
    do_cmd(32'h002A_0010, 1, 0, 3, 32'h5555_AAAA, 0, 0, 0, 3'd0);
    reset_in_wait();

    for (int n = 0; n < 150; n++) begin
      int d, acs_at;
      if (m_err != 3'd0) begin
        if ($urandom_range(0, 2) == 0) ign_cmd($urandom);
        acs_clear(3'($urandom_range(0, 7)));
        if (m_err != 3'd0) acs_clear(3'b111);
      end
      if ($urandom_range(0, 3) == 0) write_data0($urandom);
      r = $urandom;
      c = 32'd0;
      c[31:24] = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
      c[22:20] = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
      c[19]    = r[0];
      c[18]    = ($urandom_range(0, 9) == 0);
      c[17]    = ($urandom_range(0, 4) != 0);
      c[16]    = r[1];
      c[15:0]  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : r[31:16];
      d = $urandom_range(0, 4);
      acs_at = ($urandom_range(0, 7) == 0) ? $urandom_range(3, 8) : 0;
      do_cmd(c, ($urandom_range(0, 5) != 0), r[2], d, $urandom,
             ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
             acs_at, 3'($urandom_range(0, 7)));
    end

    repeat (3) @(negedge cpu_clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dbg_abs_cmd.md
DBG_ABS_CMD -- requirements
Module: dbg_abs_cmd

Interface
REQ-001 cpu_clk  input  1  cpu clock; all state updates on its rising edge.
REQ-002 cpu_rstn  input  1  cpu reset; asynchronous assertion, active low.
REQ-003 dmi_cmd_wr  input  1  one-cycle strobe: write abstract command register with dmi_wdata.
REQ-004 dmi_data0_wr  input  1  one-cycle strobe: write data0 with dmi_wdata.
REQ-005 dmi_acs_wr  input  1  one-cycle strobe: abstractcs write; dmi_wdata[10:8] clears cmderr bits (W1C).
REQ-006 dmi_wdata  input  32  DMI write data.
REQ-007 data0  output  32  data0 register contents.
REQ-008 busy  output  1  abstract command in progress.
REQ-009 cmderr  output  3  sticky command error: 0 none, 1 busy, 2 not supported, 3 exception, 4 halt/resume.
REQ-010 dbg_mode  input  1  core halted in debug mode.
REQ-011 dbg_reg_access  output  1  register access strobe to the register responders.
REQ-012 dbg_wr1_rd0  output  1  access direction: 1 write, 0 read; valid with dbg_reg_access.
REQ-013 dbg_regno  output  16  access register number; valid with dbg_reg_access.
REQ-014 dbg_write_data  output  32  write data (equals data0); valid with dbg_reg_access.
REQ-015 dbg_read_data  input  32  ORed read data from the responders.
REQ-016 dbg_read_data_valid  input  1  read data valid; may come in the strobe cycle or up to 3 cycles later.

Function
REQ-017 Command field decode: cmdtype [31:24], aarsize [22:20], postincrement [19], postexec [18], transfer [17], write [16], regno [15:0].
REQ-018 FSM states: IDLE, CHECK, EXEC, WAIT, DONE; busy = 1 in every state except IDLE.
REQ-019 IDLE: if dmi_cmd_wr is high and cmderr == 0, latch dmi_wdata into the command register and go to CHECK; if cmderr != 0, ignore the command and stay in IDLE.
REQ-020 CHECK, first matching rule wins:
  - cmdtype != 0, or postexec == 1, or (transfer == 1 and aarsize != 2): cmderr = 2, go to DONE.
  - dbg_mode == 0: cmderr = 4, go to DONE.
  - transfer == 0: go to DONE.
  - otherwise: go to EXEC.
REQ-021 EXEC lasts exactly one cycle with dbg_reg_access = 1; dbg_wr1_rd0 = write, dbg_regno = regno, dbg_write_data = data0.
REQ-022 dbg_reg_access, dbg_wr1_rd0, dbg_regno and dbg_write_data are 0 outside EXEC.
REQ-023 EXEC write: completes in that cycle; go to DONE.
REQ-024 EXEC read: if dbg_read_data_valid, load dbg_read_data into data0 and go to DONE; else go to WAIT.
REQ-025 WAIT: a 2-bit counter starts at 0 on entry.
  - If dbg_read_data_valid: load data0 and go to DONE.
  - Else if the counter == 2 (third WAIT cycle): cmderr = 3, data0 unchanged, go to DONE.
  - Else increment the counter.
REQ-026 DONE, one cycle: if the command had transfer == 1, postincrement == 1 and set no error, regno <= regno + 1 (16-bit, 0xFFFF wraps to 0x0000); then go to IDLE.
REQ-027 Latency, write command with dmi_cmd_wr at cycle T: busy = 1 from T+1; dbg_reg_access = 1 at T+2; busy = 0 from T+4.
REQ-028 dmi_cmd_wr while busy: cmderr = 1 if cmderr == 0 (otherwise unchanged); the command register is not modified.
REQ-029 dmi_data0_wr while busy: cmderr = 1 if cmderr == 0; data0 is not modified.
REQ-030 dmi_data0_wr in IDLE updates data0 on the next edge.
REQ-031 cmderr is sticky; only dmi_acs_wr clears it, bitwise, cmderr <= cmderr & ~dmi_wdata[10:8].
REQ-032 Same-cycle error set and dmi_acs_wr: the set wins.
REQ-033 dbg_mode dropping during EXEC or WAIT does not abort the command.

Reset
REQ-034 Asynchronous cpu_rstn low forces, immediately:
  - FSM to IDLE and the WAIT counter to 0;
  - busy = 0, cmderr = 0, data0 = 0, command register = 0;
  - all dbg_* outputs = 0.
REQ-035 Reset asserted mid-command abandons the command with no responder access after reset release.

Verification
REQ-036 dbg_mode = 1; data0 <= 0x12345678; command 0x0023_07B0 (write, transfer, aarsize 2, regno 0x7B0) -> one-cycle dbg_reg_access at T+2 with dbg_wr1_rd0 = 1, dbg_regno = 0x07B0, dbg_write_data = 0x12345678; busy low at T+4; cmderr = 0.
REQ-037 Read command 0x0022_07A1 with responder valid in the strobe cycle, data 0xDEADBEEF -> data0 = 0xDEADBEEF; cmderr = 0.
REQ-038 Read with no dbg_read_data_valid -> cmderr = 3 after 3 WAIT cycles; data0 unchanged; then dmi_acs_wr with dmi_wdata[10:8] = 3'b111 -> cmderr = 0.
REQ-039 dbg_mode = 0, any valid transfer command -> cmderr = 4 and no dbg_reg_access; next command ignored until cmderr is cleared.
REQ-040 Command 0x002A_FFFF (postincrement read) with valid read -> regno becomes 0x0000; command with aarsize 3 -> cmderr = 2 and no access.
REQ-041 dmi_cmd_wr and dmi_data0_wr during busy -> cmderr = 1; running command completes unchanged; data0 not overwritten; cpu_rstn pulse in WAIT -> all outputs 0 and no further access.
